// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for a 5-stage pipeline.
// Optional stall_count performance counter enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic [4:0]  ID_EX_Rt,
  input  logic        ID_EX_MemtoReg,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        EX_MEM_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        MEM_WB_Flush,
  output logic [1:0]  hz_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    BR_FLUSH   = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   mem_stall;
  logic   load_use;

  assign mem_stall = dmem_req && !dmem_ready;
  assign load_use  = ID_EX_MemtoReg && (ID_EX_Rt != 5'd0) &&
                     ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

  always_comb begin
    state_d      = RUN;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    MEM_WB_Flush = 1'b0;

    // An outstanding memory access freezes everything, whatever state we are in.
    if (mem_stall) begin
      state_d      = MEM_WAIT;
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (branch_taken) begin
            state_d     = BR_FLUSH;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
          end else if (load_use) begin
            state_d     = LOAD_STALL;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end
        end
        BR_FLUSH: begin
          IF_ID_Flush = 1'b1;
        end
        default: begin
        end
      endcase
    end

    if (!rst_n) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      IF_ID_Flush  = 1'b0;
      ID_EX_Flush  = 1'b0;
      MEM_WB_Flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign hz_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (!PCWrite && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule
